uart_fifo_ctl: RTL and testbench

UART_FIFO_CTL -- requirements
Module: uart_fifo_ctl

---
 rtl/uart_fifo_ctl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_fifo_ctl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctl.sv
// Memory-mapped UART: TX/RX FIFOs, TX drain FSM, level interrupt and the serial engines.
// DIVIDER is the number of clocks per serial bit, shared by transmitter and receiver.
module uart_fifo_ctl #(
   parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
   parameter int          PAYLOAD_BITS    = 8,
   parameter int          STOP_BITS       = 1,
   parameter int          TX_DEPTH        = 8,
   parameter int          RX_DEPTH        = 8,
   parameter int          DIV_BITS        = 16,
   parameter int          DEFAULT_DIVIDER = 556
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   input  logic        uart_rx,
   output logic        irq
);
   localparam int P     = PAYLOAD_BITS;
   localparam int TXW   = $clog2(TX_DEPTH);
   localparam int RXW   = $clog2(RX_DEPTH);
   localparam int TXC   = $clog2(TX_DEPTH + 1);
   localparam int RXC   = $clog2(RX_DEPTH + 1);
   localparam int FRAME = PAYLOAD_BITS + STOP_BITS + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

   logic [DIV_BITS-1:0] r_divider;
   logic                r_tx_en, r_rx_en, r_ie_rx, r_ie_tx;
   logic                r_rx_ovf, r_rx_brk, r_tx_ovf, r_irq;
   tx_state_t           r_state;

   logic [P-1:0]        r_tx_mem [TX_DEPTH];
   logic [TXW-1:0]      r_tx_wr, r_tx_rd;
   logic [TXC-1:0]      r_tx_cnt;
   logic [P-1:0]        r_rx_mem [RX_DEPTH];
   logic [RXW-1:0]      r_rx_wr, r_rx_rd;
   logic [RXC-1:0]      r_rx_cnt;

   logic [FRAME-1:0]    r_utx_shift;
   logic [DIV_BITS-1:0] r_utx_cnt;
   logic [3:0]          r_utx_bits;
   logic                r_utx_busy, r_utx_start;
   logic [P-1:0]        r_utx_data;

   logic [1:0]          r_urx_sync;
   logic                r_urx_busy, r_urx_valid, r_urx_break;
   logic [DIV_BITS-1:0] r_urx_cnt;
   logic [3:0]          r_urx_bits;
   logic [P-1:0]        r_urx_data;

   logic [7:0]          w_off;
   logic                w_hit, w_wr, w_rd, w_ctrl_wr, w_status_wr;
   logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_active;
   logic                w_tx_push_req, w_tx_push, w_tx_pop, w_tx_flush;
   logic                w_rx_push_req, w_rx_push, w_rx_pop, w_rx_flush;
   logic [DIV_BITS:0]   w_utx_inc, w_urx_inc, w_urx_target;
   logic                w_urx_line;
   logic                w_unused_wdata;

   assign w_off         = mem_addr[7:0];
   assign w_hit         = (mem_addr[31:8] == BASE_ADDR[31:8]);
   assign w_wr          = w_hit && mem_we;
   assign w_rd          = w_hit && mem_re;
   assign w_ctrl_wr     = w_wr && (w_off == 8'h0C);
   assign w_status_wr   = w_wr && (w_off == 8'h04);
   assign w_tx_empty    = (r_tx_cnt == TXC'(0));
   assign w_tx_full     = (r_tx_cnt == TXC'(TX_DEPTH));
   assign w_rx_empty    = (r_rx_cnt == RXC'(0));
   assign w_rx_full     = (r_rx_cnt == RXC'(RX_DEPTH));
   assign w_tx_active   = !w_tx_empty || (r_state != S_IDLE);
   assign w_tx_flush    = w_ctrl_wr && mem_wdata[4];
   assign w_rx_flush    = w_ctrl_wr && mem_wdata[5];
   assign w_tx_pop      = (r_state == S_LOAD) && !w_tx_empty;
   assign w_tx_push_req = w_wr && (w_off == 8'h00);
   assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
   assign w_rx_pop      = w_rd && (w_off == 8'h08) && !w_rx_empty;
   assign w_rx_push_req = r_urx_valid && r_rx_en;
   assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);
   assign w_utx_inc     = {1'b0, r_utx_cnt} + (DIV_BITS+1)'(1);
   assign w_urx_inc     = {1'b0, r_urx_cnt} + (DIV_BITS+1)'(1);
   assign w_urx_target  = (r_urx_bits == 4'd0) ? {2'b00, r_divider[DIV_BITS-1:1]} : {1'b0, r_divider};
   assign w_urx_line    = r_urx_sync[1];
   assign w_unused_wdata = ^mem_wdata;
   assign uart_tx       = r_utx_shift[0];
   assign irq           = r_irq;

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= mem_wdata[P-1:0];
      if (w_rx_push) r_rx_mem[r_rx_wr] <= r_urx_data;
   end

   // FIFO pointers and counts; a flush wins over any same-cycle push or pop
   always_ff @(posedge clk) begin
      if (rst || w_tx_flush) begin
         r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + TXW'(1);
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + TXW'(1);
         r_tx_cnt <= r_tx_cnt + TXC'(w_tx_push) - TXC'(w_tx_pop);
      end
      if (rst || w_rx_flush) begin
         r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wr <= r_rx_wr + RXW'(1);
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + RXW'(1);
         r_rx_cnt <= r_rx_cnt + RXC'(w_rx_push) - RXC'(w_rx_pop);
      end
   end

   // Control, divider, sticky flags (set beats W1C) and registered interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         r_divider <= DIV_BITS'(DEFAULT_DIVIDER);
         {r_ie_tx, r_ie_rx, r_rx_en, r_tx_en} <= 4'b0000;
         {r_tx_ovf, r_rx_brk, r_rx_ovf, r_irq} <= 4'b0000;
      end else begin
         if (w_ctrl_wr) {r_ie_tx, r_ie_rx, r_rx_en, r_tx_en} <= mem_wdata[3:0];
         if (w_wr && (w_off == 8'h10)) r_divider <= mem_wdata[DIV_BITS-1:0];
         r_tx_ovf <= (w_tx_push_req && w_tx_full && !w_tx_pop) || (r_tx_ovf && !(w_status_wr && mem_wdata[7]));
         r_rx_ovf <= (w_rx_push_req && w_rx_full && !w_rx_pop) || (r_rx_ovf && !(w_status_wr && mem_wdata[5]));
         r_rx_brk <= r_urx_break || (r_rx_brk && !(w_status_wr && mem_wdata[6]));
         r_irq    <= (r_ie_rx && !w_rx_empty) || (r_ie_tx && w_tx_empty && (r_state == S_IDLE))
                     || r_rx_ovf || r_tx_ovf;
      end
   end

   // TX drain FSM: head is captured on leaving IDLE so a flush cannot corrupt a loaded frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE; r_utx_start <= 1'b0; r_utx_data <= '0;
      end else begin
         r_utx_start <= 1'b0;
         case (r_state)
            S_IDLE: if (r_tx_en && !w_tx_empty) begin
               r_state     <= S_LOAD;
               r_utx_start <= 1'b1;
               r_utx_data  <= r_tx_mem[r_tx_rd];
            end
            S_LOAD:      r_state <= S_WAIT_BUSY;
            S_WAIT_BUSY: if (r_utx_busy) r_state <= S_WAIT_DONE;
            S_WAIT_DONE: if (!r_utx_busy) r_state <= S_IDLE;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   // Serial transmitter: start bit, payload LSB first, stop bits; line idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         r_utx_shift <= '1; r_utx_cnt <= '0; r_utx_bits <= '0; r_utx_busy <= 1'b0;
      end else if (!r_utx_busy) begin
         r_utx_cnt  <= '0;
         r_utx_bits <= '0;
         if (r_utx_start) begin
            r_utx_shift <= {{STOP_BITS{1'b1}}, r_utx_data, 1'b0};
            r_utx_busy  <= 1'b1;
         end
      end else if (w_utx_inc >= {1'b0, r_divider}) begin
         r_utx_cnt   <= '0;
         r_utx_shift <= {1'b1, r_utx_shift[FRAME-1:1]};
         r_utx_bits  <= r_utx_bits + 4'd1;
         if (r_utx_bits == 4'(FRAME - 1)) r_utx_busy <= 1'b0;
      end else begin
         r_utx_cnt <= r_utx_cnt + DIV_BITS'(1);
      end
   end

   // Serial receiver: mid-bit sampling; a low stop bit with all-zero payload is a break
   always_ff @(posedge clk) begin
      if (rst) begin
         r_urx_sync <= 2'b11; r_urx_busy <= 1'b0; r_urx_cnt <= '0; r_urx_bits <= '0;
         r_urx_data <= '0; r_urx_valid <= 1'b0; r_urx_break <= 1'b0;
      end else begin
         r_urx_sync  <= {r_urx_sync[0], uart_rx};
         r_urx_valid <= 1'b0;
         r_urx_break <= 1'b0;
         if (!r_urx_busy) begin
            r_urx_cnt  <= '0;
            r_urx_bits <= '0;
            if (!w_urx_line) r_urx_busy <= 1'b1;
         end else if (w_urx_inc >= w_urx_target) begin
            r_urx_cnt  <= '0;
            r_urx_bits <= r_urx_bits + 4'd1;
            if (r_urx_bits == 4'd0) begin
               if (w_urx_line) r_urx_busy <= 1'b0;
            end else if (r_urx_bits <= 4'(P)) begin
               r_urx_data <= {w_urx_line, r_urx_data[P-1:1]};
            end else begin
               r_urx_busy  <= 1'b0;
               r_urx_valid <= w_urx_line;
               r_urx_break <= !w_urx_line && (r_urx_data == '0);
            end
         end else begin
            r_urx_cnt <= r_urx_cnt + DIV_BITS'(1);
         end
      end
   end

   // Register read mux; zero outside a hit read
   always_comb begin
      mem_rdata = 32'h0000_0000;
      if (w_rd) begin
         case (w_off)
            8'h04:   mem_rdata = {24'h00_0000, r_tx_ovf, r_rx_brk, r_rx_ovf, w_rx_full,
                                  w_rx_empty, w_tx_empty, w_tx_full, w_tx_active};
            8'h08:   mem_rdata = w_rx_empty ? 32'h0000_0000 : 32'(r_rx_mem[r_rx_rd]);
            8'h0C:   mem_rdata = {28'h000_0000, r_ie_tx, r_ie_rx, r_rx_en, r_tx_en};
            8'h10:   mem_rdata = 32'(r_divider);
            8'h14:   mem_rdata = {16'(r_tx_cnt), 16'(r_rx_cnt)};
            default: mem_rdata = 32'h0000_0000;
         endcase
      end else begin
         mem_rdata = 32'h0000_0000;
      end
   end
endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Directed self-checking bench for uart_fifo_ctl: register map, TX framing, FIFO limits,
// RX loopback, overflow, simultaneous push/pop, interrupt timing, break and mid-frame reset.
module tb_uart_fifo_ctl;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [31:0] mem_rdata;
   logic        uart_tx_s, uart_rx_s, irq_s;
   logic        loop = 1'b0;
   logic        rx_drive = 1'b1;
   logic [31:0] d;
   logic [7:0]  fb;
   logic        fok;
   int          errors = 0;
   int          checks = 0;
   int          n;

   assign uart_rx_s = loop ? uart_tx_s : rx_drive;

   uart_fifo_ctl dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .uart_tx(uart_tx_s), .uart_rx(uart_rx_s), .irq(irq_s)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data);
      mem_addr = BASE | 32'(off); mem_wdata = data; mem_we = 1'b1;
      @(negedge clk);
      mem_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      mem_addr = addr; mem_re = 1'b1;
      #1 data = mem_rdata;
      @(negedge clk);
      mem_re = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   // Decode one frame on uart_tx at 4 clocks per bit, sampling mid-bit
   task automatic tx_frame(output logic [7:0] data, output logic ok);
      int k = 0;
      ok = 1'b0; data = 8'h00;
      while (uart_tx_s !== 1'b0 && k < 300) begin @(negedge clk); k++; end
      if (uart_tx_s === 1'b0) begin
         repeat (5) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            data[i] = uart_tx_s;
            repeat (4) @(negedge clk);
         end
         ok = (uart_tx_s === 1'b1);
      end
   endtask

   initial begin
      idle(3);
      check("reset_tx_line", 32'(uart_tx_s), 32'h1);
      check("reset_irq", 32'(irq_s), 32'h0);
      rst = 1'b0;
      rd(BASE | 32'h10, d); check("reset_divider", d, 32'd556);
      rd(BASE | 32'h04, d); check("reset_status", d, 32'h0000_000C);
      rd(BASE | 32'h14, d); check("reset_level", d, 32'h0);
      rd(BASE | 32'h0C, d); check("reset_ctrl", d, 32'h0);
      rd(BASE | 32'h18, d); check("unmapped_read", d, 32'h0);
      rd(32'h5000_0010, d); check("miss_read", d, 32'h0);

      wr(8'h10, 32'd4);
      rd(BASE | 32'h10, d); check("divider_wr", d, 32'd4);
      wr(8'h00, 32'h41); wr(8'h00, 32'h42); wr(8'h00, 32'h43);
      rd(BASE | 32'h14, d); check("level_tx3", d, 32'h0003_0000);
      wr(8'h0C, 32'h1);
      tx_frame(fb, fok); check("frame0", {23'h0, fok, fb}, 32'h141);
      tx_frame(fb, fok); check("frame1", {23'h0, fok, fb}, 32'h142);
      tx_frame(fb, fok); check("frame2", {23'h0, fok, fb}, 32'h143);
      idle(10);
      rd(BASE | 32'h04, d); check("tx_done_status", d, 32'h0000_000C);

      wr(8'h0C, 32'h0);
      for (int i = 0; i < 9; i++) wr(8'h00, 32'h10 + 32'(i));
      rd(BASE | 32'h14, d); check("level_tx_full", d, 32'h0008_0000);
      rd(BASE | 32'h04, d); check("status_tx_ovf", d, 32'h0000_008B);
      check("irq_tx_ovf", 32'(irq_s), 32'h1);
      wr(8'h04, 32'h80);
      rd(BASE | 32'h04, d); check("status_w1c", d, 32'h0000_000B);
      idle(1);
      check("irq_cleared", 32'(irq_s), 32'h0);
      wr(8'h0C, 32'h10);
      rd(BASE | 32'h14, d); check("level_tx_flush", d, 32'h0);
      rd(BASE | 32'h0C, d); check("ctrl_flush_selfclr", d, 32'h0);

      loop = 1'b1;
      wr(8'h0C, 32'h2);
      for (int i = 0; i < 8; i++) wr(8'h00, 32'(i));
      wr(8'h0C, 32'h3);
      idle(30);
      wr(8'h00, 32'h08);
      idle(450);
      rd(BASE | 32'h14, d); check("level_rx_full", d, 32'h0000_0008);
      rd(BASE | 32'h04, d); check("status_rx_ovf", d, 32'h0000_0034);
      check("irq_rx_ovf", 32'(irq_s), 32'h1);
      for (int i = 0; i < 8; i++) begin
         rd(BASE | 32'h08, d); check("rx_loop_data", d, 32'(i));
      end
      rd(BASE | 32'h04, d); check("status_rx_drained", d, 32'h0000_002C);
      rd(BASE | 32'h08, d); check("rx_empty_read", d, 32'h0);
      rd(BASE | 32'h14, d); check("level_rx_empty", d, 32'h0);
      wr(8'h04, 32'h20);

      for (int i = 0; i < 8; i++) wr(8'h00, 32'h30 + 32'(i));
      idle(400);
      rd(BASE | 32'h14, d); check("level_rx_refill", d, 32'h0000_0008);
      wr(8'h00, 32'h38);
      n = 0;
      while (dut.r_urx_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("rx_valid_seen", 32'(n < 200), 32'h1);
      rd(BASE | 32'h08, d); check("pushpop_head", d, 32'h30);
      rd(BASE | 32'h14, d); check("pushpop_level", d, 32'h0000_0008);
      rd(BASE | 32'h04, d); check("pushpop_no_ovf", d & 32'h20, 32'h0);
      wr(8'h0C, 32'h23);
      rd(BASE | 32'h14, d); check("level_rx_flush", d, 32'h0);
      rd(BASE | 32'h0C, d); check("ctrl_after_flush", d, 32'h3);

      wr(8'h0C, 32'h7);
      wr(8'h00, 32'h5A);
      n = 0;
      while (irq_s !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("irq_rx_rise", 32'(irq_s), 32'h1);
      rd(BASE | 32'h08, d); check("irq_rx_data", d, 32'h5A);
      check("irq_hold_pop_cycle", 32'(irq_s), 32'h1);
      idle(1);
      check("irq_rx_fall", 32'(irq_s), 32'h0);

      loop = 1'b0;
      wr(8'h0C, 32'h1);
      rx_drive = 1'b0;
      idle(45);
      rx_drive = 1'b1;
      idle(60);
      rd(BASE | 32'h04, d); check("rx_break_set", d & 32'h40, 32'h40);
      wr(8'h04, 32'h40);
      rd(BASE | 32'h04, d); check("rx_break_clr", d & 32'h40, 32'h0);
      rd(BASE | 32'h14, d); check("break_no_push", d, 32'h0);

      wr(8'h00, 32'h55);
      idle(8);
      rst = 1'b1;
      idle(1);
      check("reset_midframe_line", 32'(uart_tx_s), 32'h1);
      rst = 1'b0;
      rd(BASE | 32'h10, d); check("reset2_divider", d, 32'd556);
      rd(BASE | 32'h0C, d); check("reset2_ctrl", d, 32'h0);
      rd(BASE | 32'h14, d); check("reset2_level", d, 32'h0);
      idle(50);
      check("reset2_line_idle", 32'(uart_tx_s), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
